// File: rtl/int_exec_lane_mc_if.sv
// Handshake and data bundle between the register-read stage, one integer
// execution lane and the register-write stage.
//   master : issue side (register read, flush control, stall)
//   slave  : the execution lane
// Signals: stall; issue group in_*; flush group flush_*; result group out_*;
// branch resolution group br_*.
interface int_exec_lane_mc_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int AL_PTR_WIDTH = 6,
  parameter int DISP_WIDTH   = 20
);
  logic                    stall;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              in_op;
  logic [2:0]              in_cond;
  logic [DATA_WIDTH-1:0]   in_a;
  logic [DATA_WIDTH-1:0]   in_b;
  logic [DATA_WIDTH-1:0]   in_pc;
  logic [DISP_WIDTH-1:0]   in_disp;
  logic                    in_pred_taken;
  logic [DATA_WIDTH-1:0]   in_pred_addr;
  logic [AL_PTR_WIDTH-1:0] in_al_ptr;
  logic                    flush_valid;
  logic [AL_PTR_WIDTH-1:0] flush_head;
  logic [AL_PTR_WIDTH-1:0] flush_tail;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [AL_PTR_WIDTH-1:0] out_al_ptr;
  logic                    br_valid;
  logic                    br_taken;
  logic                    br_mispred;
  logic [DATA_WIDTH-1:0]   br_next_addr;

  modport master (
    output stall, in_valid, in_op, in_cond, in_a, in_b, in_pc, in_disp,
           in_pred_taken, in_pred_addr, in_al_ptr,
           flush_valid, flush_head, flush_tail,
    input  in_ready, out_valid, out_data, out_al_ptr,
           br_valid, br_taken, br_mispred, br_next_addr
  );

  modport slave (
    input  stall, in_valid, in_op, in_cond, in_a, in_b, in_pc, in_disp,
           in_pred_taken, in_pred_addr, in_al_ptr,
           flush_valid, flush_head, flush_tail,
    output in_ready, out_valid, out_data, out_al_ptr,
           br_valid, br_taken, br_mispred, br_next_addr
  );
endinterface

// File: rtl/int_exec_lane_mc.sv
// Integer execution lane: single-cycle ALU / shift / branch / JALR ops plus an
// iterative radix-2 restoring divider (DIV/DIVU/REM/REMU, DATA_WIDTH+2 cycles).
// Ops and in-flight results are killed when their active-list pointer falls in
// the wrapping flush range [flush_head, flush_tail).
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset (0 = reset)
//   lane : int_exec_lane_mc_if.slave (stall, issue, flush, result, branch)
module int_exec_lane_mc #(
  parameter int DATA_WIDTH   = 32,
  parameter int AL_PTR_WIDTH = 6,
  parameter int DISP_WIDTH   = 20
) (
  input  logic              clk,
  input  logic              rst,
  int_exec_lane_mc_if.slave lane
);
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL,
    OP_SRL, OP_SRA, OP_BR, OP_JALR, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_e;

  state_e                  state;
  logic [SHW-1:0]          count;
  logic [DATA_WIDTH-1:0]   div_q;      // dividend shifting out, quotient in
  logic [DATA_WIDTH-1:0]   div_r;      // partial remainder
  logic [DATA_WIDTH-1:0]   div_b;      // divisor magnitude
  logic                    div_neg_q, div_neg_r, div_by_zero, div_is_rem;
  logic [AL_PTR_WIDTH-1:0] div_ptr;

  logic                    out_reg_valid;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic [AL_PTR_WIDTH-1:0] out_ptr_r;
  logic                    br_valid_r, br_taken_r, br_mispred_r;
  logic [DATA_WIDTH-1:0]   br_next_r;

  // Wrapping range test; head == tail is the empty range.
  function automatic logic in_range(input logic [AL_PTR_WIDTH-1:0] p,
                                    input logic [AL_PTR_WIDTH-1:0] head,
                                    input logic [AL_PTR_WIDTH-1:0] tail);
    if (head <= tail) return (p >= head) && (p < tail);
    return (p >= head) || (p < tail);
  endfunction

  logic kill_in, kill_out, kill_div;
  assign kill_in  = lane.flush_valid && in_range(lane.in_al_ptr, lane.flush_head, lane.flush_tail);
  assign kill_out = lane.flush_valid && in_range(out_ptr_r, lane.flush_head, lane.flush_tail);
  assign kill_div = lane.flush_valid && in_range(div_ptr, lane.flush_head, lane.flush_tail);

  // NOTE: ready is gated by rst so that every output reads 0 while reset is held.
  logic ready, accept;
  op_e  op;
  assign ready  = rst && (state == IDLE) && !lane.stall;
  assign accept = lane.in_valid && ready && !kill_in;
  assign op     = op_e'(lane.in_op);

  logic is_div, is_signed_div;
  assign is_div        = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  assign is_signed_div = (op == OP_DIV) || (op == OP_REM);

  // Single-cycle datapath.
  logic [DATA_WIDTH-1:0] disp_ext, pc_plus4, alu_res, target, next_addr;
  logic [SHW-1:0]        shamt;
  logic                  eq, lt_s, lt_u, is_branch, taken, mispred;

  assign disp_ext = {{(DATA_WIDTH-DISP_WIDTH){lane.in_disp[DISP_WIDTH-1]}}, lane.in_disp};
  assign pc_plus4 = lane.in_pc + DATA_WIDTH'(4);
  assign shamt    = lane.in_b[SHW-1:0];
  assign eq       = lane.in_a == lane.in_b;
  assign lt_s     = $signed(lane.in_a) < $signed(lane.in_b);
  assign lt_u     = lane.in_a < lane.in_b;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_res   = '0;
    is_branch = 1'b0;
    taken     = 1'b0;
    target    = '0;
    case (op)
      OP_ADD:  alu_res = lane.in_a + lane.in_b;
      OP_SUB:  alu_res = lane.in_a - lane.in_b;
      OP_AND:  alu_res = lane.in_a & lane.in_b;
      OP_OR:   alu_res = lane.in_a | lane.in_b;
      OP_XOR:  alu_res = lane.in_a ^ lane.in_b;
      OP_SLT:  alu_res = DATA_WIDTH'(lt_s);
      OP_SLTU: alu_res = DATA_WIDTH'(lt_u);
      OP_SLL:  alu_res = lane.in_a << shamt;
      OP_SRL:  alu_res = lane.in_a >> shamt;
      OP_SRA:  alu_res = $signed(lane.in_a) >>> shamt;
      OP_BR: begin
        alu_res   = pc_plus4;
        is_branch = 1'b1;
        target    = lane.in_pc + disp_ext;
        case (lane.in_cond)
          3'd0:    taken = eq;
          3'd1:    taken = !eq;
          3'd2:    taken = lt_s;
          3'd3:    taken = lt_u;
          3'd4:    taken = !lt_s;
          3'd5:    taken = !lt_u;
          default: taken = 1'b1;
        endcase
      end
      OP_JALR: begin
        alu_res   = pc_plus4;
        is_branch = 1'b1;
        taken     = 1'b1;
        target    = (lane.in_a + disp_ext) & ~DATA_WIDTH'(1);
      end
      default: alu_res = '0;
    endcase
  end

  assign next_addr = taken ? target : pc_plus4;
  assign mispred   = is_branch && ((lane.in_pred_taken != taken) ||
                                   (taken && (lane.in_pred_addr != next_addr)));

  // Operand magnitudes for the divider.
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  assign a_neg = is_signed_div && lane.in_a[DATA_WIDTH-1];
  assign b_neg = is_signed_div && lane.in_b[DATA_WIDTH-1];
  assign abs_a = a_neg ? -lane.in_a : lane.in_a;
  assign abs_b = b_neg ? -lane.in_b : lane.in_b;

  // One restoring step: shift next dividend bit into the remainder, subtract
  // the divisor if it fits. A zero divisor always fits, which yields an
  // all-ones quotient and leaves the dividend in the remainder.
  logic [DATA_WIDTH:0]   shifted, trial;
  logic [DATA_WIDTH-1:0] q_fix, r_fix;
  assign shifted = {div_r, div_q[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, div_b};
  assign q_fix   = div_by_zero ? '1 : (div_neg_q ? -div_q : div_q);
  assign r_fix   = div_neg_r ? -div_r : div_r;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      div_q         <= '0;
      div_r         <= '0;
      div_b         <= '0;
      div_neg_q     <= 1'b0;
      div_neg_r     <= 1'b0;
      div_by_zero   <= 1'b0;
      div_is_rem    <= 1'b0;
      div_ptr       <= '0;
      out_reg_valid <= 1'b0;
      out_data_r    <= '0;
      out_ptr_r     <= '0;
      br_valid_r    <= 1'b0;
      br_taken_r    <= 1'b0;
      br_mispred_r  <= 1'b0;
      br_next_r     <= '0;
    end else if (lane.stall) begin
      // Frozen, except that flushes still take effect.
      if (kill_out) out_reg_valid <= 1'b0;
      if (state != IDLE && kill_div) state <= IDLE;
    end else begin
      out_reg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_div) begin
            state       <= DIV_RUN;
            count       <= '0;
            div_q       <= abs_a;
            div_r       <= '0;
            div_b       <= abs_b;
            div_neg_q   <= a_neg ^ b_neg;
            div_neg_r   <= a_neg;
            div_by_zero <= (lane.in_b == '0);
            div_is_rem  <= (op == OP_REM) || (op == OP_REMU);
            div_ptr     <= lane.in_al_ptr;
          end else if (accept) begin
            out_reg_valid <= 1'b1;
            out_data_r    <= alu_res;
            out_ptr_r     <= lane.in_al_ptr;
            br_valid_r    <= is_branch;
            br_taken_r    <= taken;
            br_mispred_r  <= mispred;
            br_next_r     <= is_branch ? next_addr : '0;
          end
        end
        DIV_RUN: begin
          if (kill_div) begin
            state <= IDLE;
          end else begin
            if (!trial[DATA_WIDTH]) begin
              div_r <= trial[DATA_WIDTH-1:0];
              div_q <= {div_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
              div_r <= shifted[DATA_WIDTH-1:0];
              div_q <= {div_q[DATA_WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == SHW'(DATA_WIDTH-1)) state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          state <= IDLE;
          if (!kill_div) begin
            out_reg_valid <= 1'b1;
            out_data_r    <= div_is_rem ? r_fix : q_fix;
            out_ptr_r     <= div_ptr;
            br_valid_r    <= 1'b0;
            br_taken_r    <= 1'b0;
            br_mispred_r  <= 1'b0;
            br_next_r     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic out_valid_w;
  assign out_valid_w       = out_reg_valid && !kill_out;
  assign lane.in_ready     = ready;
  assign lane.out_valid    = out_valid_w;
  assign lane.out_data     = out_data_r;
  assign lane.out_al_ptr   = out_ptr_r;
  assign lane.br_valid     = br_valid_r && out_valid_w;
  assign lane.br_taken     = br_taken_r && out_valid_w;
  assign lane.br_mispred   = br_mispred_r && out_valid_w;
  assign lane.br_next_addr = br_next_r;
endmodule
